// File: rtl/uart_ctrl_pkg.sv
`timescale 1ns/1ps
// uart_ctrl_pkg
// Shared definitions for the UART host controller: register addresses,
// STATUS and CTRL bit positions, FSM state encodings and a helper that
// assembles the STATUS byte.
package uart_ctrl_pkg;

  // Register map.
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // STATUS bit positions (bit 7 always reads 0).
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_RX_OVF      = 4;
  localparam int ST_TX_OVF      = 5;
  localparam int ST_TX_BUSY     = 6;

  // CTRL bit positions (write 1 to clear the matching sticky flag).
  localparam int CTRL_CLR_RX_OVF = 0;
  localparam int CTRL_CLR_TX_OVF = 1;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_BUSY    = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_WAIT = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  function automatic logic [7:0] pack_status(
    input logic rx_nonempty,
    input logic rx_full,
    input logic tx_empty,
    input logic tx_full,
    input logic rx_ovf,
    input logic tx_ovf,
    input logic tx_busy
  );
    logic [7:0] s;
    s                 = 8'h00;
    s[ST_RX_NONEMPTY] = rx_nonempty;
    s[ST_RX_FULL]     = rx_full;
    s[ST_TX_EMPTY]    = tx_empty;
    s[ST_TX_FULL]     = tx_full;
    s[ST_RX_OVF]      = rx_ovf;
    s[ST_TX_OVF]      = tx_ovf;
    s[ST_TX_BUSY]     = tx_busy;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
`timescale 1ns/1ps
// byte_fifo
// 8-bit synchronous FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push        - write push_data; accepted when not full, or when full but
//                 a pop is taken in the same cycle
//   push_data   - byte to store
//   pop         - remove the head entry; ignored when empty
//   head        - current head entry (valid only while empty=0)
//   full, empty - occupancy flags derived from the registered count
// Callers that must not accept a push into a full FIFO even with a
// simultaneous pop gate push with full themselves.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign do_pop  = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle;
  // the head is read combinationally before the edge overwrites it.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
`timescale 1ns/1ps
// uart_host_ctrl
// Register-mapped host front end for a byte UART. A small register bus
// feeds a TX FIFO drained by the TX handshake FSM; the RX handshake FSM
// fills an RX FIFO that the bus drains through the DATA register.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   reg_addr/reg_wdata  - register select / write data
//   reg_we/reg_re       - write / read strobes
//   reg_rdata           - registered read data, valid the cycle after reg_re
//   start_tx/tx_value   - byte-transmit request and byte
//   tx_done             - transmit completion from the UART
//   rx_available/rx_value - received byte presented by the UART
//   rx_clear            - acknowledge of the received byte
//   irq                 - high while the RX FIFO holds data
module uart_host_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_we,
  input  logic       reg_re,
  output logic [7:0] reg_rdata,
  output logic       start_tx,
  output logic [7:0] tx_value,
  input  logic       tx_done,
  input  logic       rx_available,
  input  logic [7:0] rx_value,
  output logic       rx_clear,
  output logic       irq
);

  // Bus decode.
  logic wr_data_sel;
  logic wr_ctrl_sel;
  logic rd_data_sel;

  assign wr_data_sel = reg_we && (reg_addr == ADDR_DATA);
  assign wr_ctrl_sel = reg_we && (reg_addr == ADDR_CTRL);
  assign rd_data_sel = reg_re && (reg_addr == ADDR_DATA);

  // FIFOs.
  logic       tx_push;
  logic       tx_pop;
  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_push;
  logic       rx_pop;
  logic [7:0] rx_head;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_capture;

  // A full TX FIFO refuses the write even if the TX FSM pops this cycle.
  assign tx_push = wr_data_sel && !tx_full;
  assign rx_pop  = rd_data_sel && !rx_empty;
  // The RX side may push into a full FIFO when the bus pops in the same
  // cycle; the FIFO itself enforces that.
  assign rx_push = rx_capture;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (reg_wdata),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_value),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Sticky overflow flags; a set in the same cycle as a clear wins.
  logic tx_ovf_reg;
  logic rx_ovf_reg;
  logic tx_ovf_set;
  logic rx_ovf_set;
  logic tx_ovf_clr;
  logic rx_ovf_clr;

  assign tx_ovf_set = wr_data_sel && tx_full;
  assign rx_ovf_set = rx_capture && rx_full && !rx_pop;
  assign tx_ovf_clr = wr_ctrl_sel && reg_wdata[CTRL_CLR_TX_OVF];
  assign rx_ovf_clr = wr_ctrl_sel && reg_wdata[CTRL_CLR_RX_OVF];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ovf_reg <= 1'b0;
      rx_ovf_reg <= 1'b0;
    end else begin
      tx_ovf_reg <= tx_ovf_set || (tx_ovf_reg && !tx_ovf_clr);
      rx_ovf_reg <= rx_ovf_set || (rx_ovf_reg && !rx_ovf_clr);
    end
  end

  // TX FSM: state register.
  tx_state_t tx_state_reg;
  tx_state_t tx_state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
    end else begin
      tx_state_reg <= tx_state_next;
    end
  end

  // TX FSM: next state. TX_RELEASE waits for tx_done to drop so a new
  // byte is never offered while the UART still reports the old one done.
  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE:    if (!tx_empty) tx_state_next = TX_BUSY;
      TX_BUSY:    if (tx_done)   tx_state_next = TX_RELEASE;
      TX_RELEASE: if (!tx_done)  tx_state_next = TX_IDLE;
      default:                   tx_state_next = TX_IDLE;
    endcase
  end

  // TX FSM: outputs. start_tx is a decode of the state register, so it
  // is high exactly while in TX_BUSY.
  always_comb begin
    tx_pop   = 1'b0;
    start_tx = 1'b0;
    case (tx_state_reg)
      TX_IDLE: tx_pop   = !tx_empty;
      TX_BUSY: start_tx = 1'b1;
      default: ;
    endcase
  end

  logic [7:0] tx_value_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_value_reg <= 8'h00;
    end else if (tx_pop) begin
      tx_value_reg <= tx_head;
    end
  end

  assign tx_value = tx_value_reg;

  // RX FSM: state register.
  rx_state_t rx_state_reg;
  rx_state_t rx_state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg <= RX_WAIT;
    end else begin
      rx_state_reg <= rx_state_next;
    end
  end

  // RX FSM: next state.
  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_WAIT: if (rx_available)  rx_state_next = RX_ACK;
      RX_ACK:  if (!rx_available) rx_state_next = RX_WAIT;
      default:                    rx_state_next = RX_WAIT;
    endcase
  end

  // RX FSM: outputs. The byte is taken in the same cycle rx_available is
  // seen in RX_WAIT; rx_clear stays up only while in RX_ACK.
  always_comb begin
    rx_capture = 1'b0;
    rx_clear   = 1'b0;
    case (rx_state_reg)
      RX_WAIT: rx_capture = rx_available;
      RX_ACK:  rx_clear   = 1'b1;
      default: ;
    endcase
  end

  // Register read path.
  logic [7:0] status;
  logic [7:0] rdata_next;
  logic [7:0] rdata_reg;

  assign status = pack_status(!rx_empty, rx_full, tx_empty, tx_full,
                              rx_ovf_reg, tx_ovf_reg,
                              tx_state_reg != TX_IDLE);

  always_comb begin
    rdata_next = 8'h00;
    case (reg_addr)
      ADDR_DATA:   rdata_next = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: rdata_next = status;
      ADDR_CTRL:   rdata_next = 8'h00;
      ADDR_RSVD:   rdata_next = 8'h00;
      default:     rdata_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg <= 8'h00;
    end else if (reg_re) begin
      rdata_reg <= rdata_next;
    end
  end

  assign reg_rdata = rdata_reg;
  assign irq       = !rx_empty;

endmodule

// File: tb/tb_uart_host_ctrl.sv
`timescale 1ns/1ps
// Testbench for uart_host_ctrl: scoreboarded register reads and TX bytes,
// a UART transmit responder, and a queue-based reference model.
module tb_uart_host_ctrl;
  import uart_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_wdata = 8'h00;
  logic       reg_we = 1'b0;
  logic       reg_re = 1'b0;
  logic [7:0] reg_rdata;
  logic       start_tx;
  logic [7:0] tx_value;
  logic       tx_done = 1'b0;
  logic       rx_available = 1'b0;
  logic [7:0] rx_value = 8'h00;
  logic       rx_clear;
  logic       irq;

  always #5 clk = ~clk;

  uart_host_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .start_tx     (start_tx),
    .tx_value     (tx_value),
    .tx_done      (tx_done),
    .rx_available (rx_available),
    .rx_value     (rx_value),
    .rx_clear     (rx_clear),
    .irq          (irq)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", nm, act);
    end
  endfunction

  // Reference model: contents of the RX FIFO and the sticky flags.
  logic [7:0] rx_model[$];
  bit         rx_ovf_m = 1'b0;
  bit         tx_ovf_m = 1'b0;

  // Scoreboards.
  logic [7:0] tx_exp_q[$];
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];

  function automatic logic [7:0] status_exp(input int tx_n, input bit busy);
    logic [7:0] s;
    s = 8'h00;
    s[0] = (rx_model.size() != 0);
    s[1] = (rx_model.size() == DEPTH);
    s[2] = (tx_n == 0);
    s[3] = (tx_n == DEPTH);
    s[4] = rx_ovf_m;
    s[5] = tx_ovf_m;
    s[6] = busy;
    return s;
  endfunction

  // Read monitor: reg_rdata is checked the cycle after reg_re.
  logic re_d = 1'b0;
  always @(posedge clk) re_d <= reg_re && rst_n;

  always @(negedge clk) begin
    if (re_d) begin
      if (rd_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL read_unexpected: got 0x%02h, expected no read", reg_rdata);
      end else begin
        check(rd_name_q.pop_front(), reg_rdata, rd_exp_q.pop_front());
      end
    end
  end

  // TX monitor: each new start_tx must carry the next expected byte, must
  // not appear while tx_done is high, and tx_value must hold while high.
  logic       prev_start = 1'b0;
  logic [7:0] held_value = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (start_tx && !prev_start) begin
        check("tx_start_while_done", {7'b0, tx_done}, 8'h00);
        if (tx_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_value);
        end else begin
          check("tx_value", tx_value, tx_exp_q.pop_front());
        end
        held_value = tx_value;
      end else if (start_tx && (tx_value !== held_value)) begin
        check("tx_value_stable", tx_value, held_value);
      end
      prev_start = start_tx;
    end
  end

  // UART transmit responder.
  bit tx_resp_en = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_resp_en && start_tx && !tx_done) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_done = 1'b1;
        for (int i = 0; i < 50 && start_tx; i++) @(negedge clk);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] d, input bit accept);
    if (accept) tx_exp_q.push_back(d);
    else        tx_ovf_m = 1'b1;
    bus_write(ADDR_DATA, d);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    reg_addr = a;
    reg_re   = 1'b1;
    tick();
    reg_re   = 1'b0;
  endtask

  task automatic rx_read_data(input string nm);
    logic [7:0] e;
    e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
    bus_read(ADDR_DATA, e, nm);
  endtask

  task automatic status_read(input int tx_n, input bit busy, input string nm);
    bus_read(ADDR_STATUS, status_exp(tx_n, busy), nm);
  endtask

  task automatic rx_deliver(input logic [7:0] d);
    int hold;
    rx_value     = d;
    rx_available = 1'b1;
    tick();
    check("rx_clear_rise", {7'b0, rx_clear}, 8'h01);
    if (rx_model.size() < DEPTH) rx_model.push_back(d);
    else                         rx_ovf_m = 1'b1;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) tick();
    check("rx_clear_held", {7'b0, rx_clear}, 8'h01);
    rx_available = 1'b0;
    tick();
    check("rx_clear_fall", {7'b0, rx_clear}, 8'h00);
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || start_tx || tx_done) && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL tx_drain: got %0d bytes pending, expected 0 within 300 cycles", tx_exp_q.size());
    end
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] e;
    int m;
    int k;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_tx", {7'b0, start_tx}, 8'h00);
    check("rst_tx_value", tx_value, 8'h00);
    check("rst_rx_clear", {7'b0, rx_clear}, 8'h00);
    check("rst_reg_rdata", reg_rdata, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    tick();
    status_read(0, 0, "status_after_reset");

    // Reserved and write-only registers read as zero; reserved writes do nothing.
    bus_write(ADDR_RSVD, 8'hFF);
    bus_read(ADDR_RSVD, 8'h00, "rsvd_read");
    bus_read(ADDR_CTRL, 8'h00, "ctrl_read");
    status_read(0, 0, "status_after_rsvd_write");

    // TX path.
    tx_write(8'h55, 1'b1);
    tx_write(8'hA3, 1'b1);
    wait_tx_idle();
    status_read(0, 0, "tx_status_idle");

    // RX path.
    rx_deliver(8'h3C);
    check("irq_set", {7'b0, irq}, 8'h01);
    rx_read_data("rx_data_3c");
    check("irq_clear", {7'b0, irq}, 8'h00);

    // TX overflow with tx_done held low: one byte in flight, DEPTH queued,
    // the last one dropped.
    tx_resp_en = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) tx_write(8'($urandom_range(0, 255)), i <= DEPTH);
    status_read(DEPTH, 1, "tx_ovf_status");
    bus_write(ADDR_CTRL, 8'h02);
    tx_ovf_m = 1'b0;
    status_read(DEPTH, 1, "tx_ovf_cleared");
    tx_resp_en = 1'b1;
    wait_tx_idle();
    status_read(0, 0, "tx_ovf_drained");

    // RX overflow.
    for (int i = 0; i < DEPTH + 1; i++) rx_deliver(8'($urandom_range(0, 255)));
    status_read(0, 0, "rx_ovf_status");
    for (int i = 0; i < DEPTH + 1; i++) rx_read_data($sformatf("rx_ovf_read%0d", i));
    bus_write(ADDR_CTRL, 8'h01);
    rx_ovf_m = 1'b0;
    status_read(0, 0, "rx_ovf_cleared");

    // Bus pop and RX push on a full FIFO in the same cycle.
    for (int i = 0; i < DEPTH; i++) rx_deliver(8'($urandom_range(0, 255)));
    v = 8'($urandom_range(0, 255));
    e = rx_model.pop_front();
    rd_exp_q.push_back(e);
    rd_name_q.push_back("simul_read");
    rx_value     = v;
    rx_available = 1'b1;
    reg_addr     = ADDR_DATA;
    reg_re       = 1'b1;
    tick();
    reg_re = 1'b0;
    rx_model.push_back(v);
    check("simul_rx_clear", {7'b0, rx_clear}, 8'h01);
    rx_available = 1'b0;
    tick();
    status_read(0, 0, "simul_status");
    for (int i = 0; i < DEPTH + 1; i++) rx_read_data($sformatf("simul_drain%0d", i));

    // Randomized traffic with both paths active together.
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(1, DEPTH);
      for (int j = 0; j < m; j++) begin
        tx_write(8'($urandom_range(0, 255)), 1'b1);
        if ($urandom_range(0, 1) == 1) tick();
      end
      k = $urandom_range(1, DEPTH + 2);
      for (int j = 0; j < k; j++) rx_deliver(8'($urandom_range(0, 255)));
      wait_tx_idle();
      status_read(0, 0, $sformatf("rand%0d_status", it));
      if (rx_ovf_m) begin
        bus_write(ADDR_CTRL, 8'h01);
        rx_ovf_m = 1'b0;
      end
      n = rx_model.size();
      for (int j = 0; j <= n; j++) rx_read_data($sformatf("rand%0d_read%0d", it, j));
      check("rand_irq_low", {7'b0, irq}, 8'h00);
    end

    // Reset during TX_BUSY and RX_ACK.
    tx_resp_en = 1'b0;
    tx_write(8'h9E, 1'b1);
    tick();
    check("mid_start_tx_busy", {7'b0, start_tx}, 8'h01);
    rx_value     = 8'h42;
    rx_available = 1'b1;
    tick();
    check("mid_rx_clear_ack", {7'b0, rx_clear}, 8'h01);
    rst_n        = 1'b0;
    rx_available = 1'b0;
    tick();
    check("mid_rst_start_tx", {7'b0, start_tx}, 8'h00);
    check("mid_rst_rx_clear", {7'b0, rx_clear}, 8'h00);
    check("mid_rst_tx_value", tx_value, 8'h00);
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    rx_model.delete();
    rx_ovf_m = 1'b0;
    tx_ovf_m = 1'b0;
    status_read(0, 0, "mid_rst_status");
    tx_resp_en = 1'b1;
    repeat (10) tick();

    tests++;
    if (tx_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d tx / %0d reads pending, expected 0 / 0",
               tx_exp_q.size(), rd_exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO (power of two, >=2).
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports reg_addr in 2 (register select), reg_wdata in 8 (write data), reg_we in 1 (write strobe), reg_re in 1 (read strobe), reg_rdata out 8 (read data).
REQ-005 SHALL have ports start_tx out 1, tx_value out 8, tx_done in 1, which connect to the UART byte-transmit handshake.
REQ-006 SHALL have ports rx_available in 1, rx_value in 8, rx_clear out 1, which connect to the UART byte-receive handshake.
REQ-007 SHALL have port irq  out  1  level, high while RX FIFO non-empty.

Function
REQ-008 SHALL decode the register map as: addr 0 DATA, addr 1 STATUS (read-only), addr 2 CTRL (write-only), addr 3 reserved (reads 0, writes ignored).
REQ-009 SHALL register reg_rdata, valid the cycle after reg_re; it holds its value when reg_re is low.
REQ-010 SHALL handle a DATA write as follows: push reg_wdata into the TX FIFO; if the FIFO is full (pre-cycle state, even with a same-cycle pop), drop the byte and set sticky tx_overflow.
REQ-011 SHALL handle a DATA read as follows: return the RX FIFO head and pop it; if the FIFO is empty, return 0x00 with no pop.
REQ-012 SHALL return STATUS bits [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overflow, [5] tx_overflow, [6] tx_busy (TX FSM not TX_IDLE), [7] 0.
REQ-013 SHALL treat a CTRL write with bit0=1 as a clear of rx_overflow and bit1=1 as a clear of tx_overflow; a same-cycle set wins over clear.
REQ-014 SHALL implement the TX FSM states TX_IDLE, TX_BUSY, TX_RELEASE.
REQ-015 SHALL, in TX_IDLE with the TX FIFO non-empty, pop the head into tx_value, drive start_tx=1 and move to TX_BUSY next cycle.
REQ-016 SHALL, in TX_BUSY, hold start_tx=1 and tx_value stable; on tx_done=1 drive start_tx=0 and move to TX_RELEASE.
REQ-017 SHALL, in TX_RELEASE, hold start_tx=0 and go to TX_IDLE when tx_done=0; the next byte shall never be started while tx_done=1.
REQ-018 SHALL implement the RX FSM states RX_WAIT, RX_ACK.
REQ-019 SHALL, in RX_WAIT with rx_available=1, capture rx_value that cycle, push it (or set rx_overflow and discard if the RX FIFO is full), drive rx_clear=1 and move to RX_ACK.
REQ-020 SHALL, in RX_ACK, hold rx_clear=1 until rx_available=0, then drive rx_clear=0 and return to RX_WAIT; rx_clear shall be high for no more cycles than this, because it blocks a new reception.
REQ-021 SHALL let a same-cycle FIFO push and pop both take effect, leaving the count unchanged; the bus read pop and the RX push, and the bus write push and the TX pop, are independent.
REQ-022 SHALL run the TX and RX FSMs concurrently and independently.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, set start_tx=0, tx_value=0, rx_clear=0, reg_rdata=0, irq=0, both FIFOs empty, both overflow flags 0, FSMs in TX_IDLE and RX_WAIT.
REQ-024 SHALL abandon any in-flight byte on reset mid-transfer without retransmission; the UART shares rst_n.

Structure
REQ-025 SHALL place register addresses, STATUS/CTRL bit indices and FSM state encodings in shared package uart_ctrl_pkg.
REQ-026 SHALL instantiate sub-module byte_fifo (8-bit synchronous FIFO with push, pop, full, empty) twice, for TX and RX.

Verification
REQ-027 SHALL verify TX path: write 0x55 then 0xA3 to DATA -> start_tx rises with tx_value=0x55, held until tx_done; 0xA3 starts only after tx_done falls; STATUS[6]=0 afterward.
REQ-028 SHALL verify RX path: pulse rx_available with rx_value=0x3C -> rx_clear high until rx_available low; irq=1; DATA read returns 0x3C; irq=0 next cycle.
REQ-029 SHALL verify TX overflow: write FIFO_DEPTH+2 bytes while tx_done is held low -> tx_overflow=1, extra byte dropped; CTRL write 0x02 clears it.
REQ-030 SHALL verify RX overflow: deliver 5 bytes with DEPTH=4 and no reads -> STATUS[1]=1, STATUS[4]=1, reads return the first 4 bytes in order, then 0x00.
REQ-031 SHALL verify simultaneous events: DATA read on a full RX FIFO in the same cycle as a new rx_available -> byte accepted, count stays 4, no overflow.
REQ-032 SHALL verify reset mid-operation: assert rst_n=0 during TX_BUSY and RX_ACK -> start_tx=0, rx_clear=0, STATUS=0x04 on the next cycle.
